// File: rtl/gpi_input_conditioner_if.sv
// ============================================================================
// Module  : gpi_input_conditioner_if
// Purpose : Board-input bundle between raw switch/button pins and the GPI block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface gpi_input_conditioner_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] ack;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pending;
  logic             any_event;

  modport master (
    output raw, ack,
    input  stable, rise, fall, pending, any_event
  );

  modport slave (
    input  raw, ack,
    output stable, rise, fall, pending, any_event
  );
endinterface

`default_nettype wire

// File: rtl/gpi_input_conditioner.sv
// ============================================================================
// Module  : gpi_input_conditioner
// Purpose : Per-bit synchronizer, debounce, edge pulses and sticky event flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gpi_input_conditioner #(
  parameter int WIDTH           = 6,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50
) (
  input  wire logic               clk,
  input  wire logic               rst,
  gpi_input_conditioner_if.slave  bus
);

  localparam int            CW          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] c_CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:0]    STABLE_LO   = 1'b0;
  localparam logic [0:0]    STABLE_HI   = 1'b1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] flip_w;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] pending_q, pending_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bus.raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Each bit flips once its synchronized level has disagreed for DEBOUNCE_CYCLES samples.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          diff_w;

    assign diff_w    = sync_w[i] != stable_q[i];
    assign flip_w[i] = diff_w && (cnt_q == c_CNT_MAX);
    assign cnt_d     = (diff_w && !flip_w[i]) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign rise_d[i] = flip_w[i] && (stable_q[i] == STABLE_LO);
    assign fall_d[i] = flip_w[i] && (stable_q[i] == STABLE_HI);
  end

  assign stable_d = stable_q ^ flip_w;
  // A new rise outranks an ack arriving on the same edge.
  assign pending_d = rise_d | (pending_q & ~bus.ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pending_q <= '0;
    end else begin
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
    end
  end

  assign bus.stable    = stable_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.pending   = pending_q;
  assign bus.any_event = |(rise_q | fall_q);

endmodule

`default_nettype wire

// File: tb/tb_gpi_input_conditioner.sv
// ============================================================================
// Module  : tb_gpi_input_conditioner
// Purpose : Directed stimulus with an event scoreboard for gpi_input_conditioner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpi_input_conditioner;

  localparam int W = 6;

  typedef struct {
    int           at;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] stable;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   asserts = 0;
  int   fails = 0;
  ev_t  q[$];
  logic [W-1:0] exp_stable = '0;

  gpi_input_conditioner_if #(.WIDTH(W)) bus ();

  gpi_input_conditioner #(
    .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Event becomes visible after edge 'at'; raw driven at negedge C shows up at C+6.
  task automatic expect_ev(input int at, input logic [W-1:0] r, input logic [W-1:0] f);
    ev_t e;
    exp_stable = (exp_stable & ~f) | r;
    e.at = at; e.rise = r; e.fall = f; e.stable = exp_stable;
    q.push_back(e);
  endtask

  // Monitor: every presented event is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      chk("any_event_or", {31'd0, bus.any_event}, {31'd0, |(bus.rise | bus.fall)});
      chk("rise_and_fall", {26'd0, bus.rise & bus.fall}, 32'd0);
      if (bus.any_event) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {20'd0, bus.rise, bus.fall}, 32'd0);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("event_cycle", cyc, e.at);
          chk("event_rise", {26'd0, bus.rise}, {26'd0, e.rise});
          chk("event_fall", {26'd0, bus.fall}, {26'd0, e.fall});
          chk("event_stable", {26'd0, bus.stable}, {26'd0, e.stable});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.raw = '0;
    bus.ack = '0;
    step(3);
    chk("reset_stable",  {26'd0, bus.stable},  32'd0);
    chk("reset_rise",    {26'd0, bus.rise},    32'd0);
    chk("reset_fall",    {26'd0, bus.fall},    32'd0);
    chk("reset_pending", {26'd0, bus.pending}, 32'd0);
    chk("reset_any",     {31'd0, bus.any_event}, 32'd0);
    rst = 1'b0;
    step(2);

    // 1: single held rise on bit 0
    bus.raw[0] = 1'b1; expect_ev(cyc + 6, 6'h01, 6'h00);
    step(8);
    chk("t1_stable",  {26'd0, bus.stable},  32'h01);
    chk("t1_pending", {26'd0, bus.pending}, 32'h01);

    // 2: 3-cycle glitch on bit 1 is rejected
    bus.raw[1] = 1'b1; step(3); bus.raw[1] = 1'b0;
    step(10);
    chk("t2_stable",  {26'd0, bus.stable},  32'h01);
    chk("t2_pending", {26'd0, bus.pending}, 32'h01);

    // 3: bouncing bit 2, then held high
    for (int k = 0; k < 6; k++) begin
      bus.raw[2] = ~bus.raw[2];
      step(2);
    end
    chk("t3_no_early_stable", {26'd0, bus.stable}, 32'h01);
    bus.raw[2] = 1'b1; expect_ev(cyc + 6, 6'h04, 6'h00);
    step(8);
    chk("t3_stable",  {26'd0, bus.stable},  32'h05);
    chk("t3_pending", {26'd0, bus.pending}, 32'h05);

    // 4: ack clears bit 0; ack on a clear bit does nothing; set beats same-edge ack
    bus.ack = 6'h01; step(1); bus.ack = '0;
    chk("t4_ack_clear", {26'd0, bus.pending}, 32'h04);
    bus.ack = 6'h02; step(1); bus.ack = '0;
    chk("t4_ack_idle", {26'd0, bus.pending}, 32'h04);
    bus.raw[3] = 1'b1; expect_ev(cyc + 6, 6'h08, 6'h00);
    step(5);
    bus.ack = 6'h08; step(1);
    chk("t4_set_wins", {31'd0, bus.pending[3]}, 32'd1);
    bus.ack = '0;
    step(2);
    chk("t4_pending", {26'd0, bus.pending}, 32'h0C);

    // 5: reset in the middle of a fall debounce
    bus.raw[4] = 1'b1; expect_ev(cyc + 6, 6'h10, 6'h00);
    step(8);
    chk("t5_stable_hi", {26'd0, bus.stable}, 32'h1D);
    bus.raw = '0;
    step(3);
    rst = 1'b1; step(1); rst = 1'b0;
    exp_stable = '0;
    chk("t5_rst_stable",  {26'd0, bus.stable},  32'd0);
    chk("t5_rst_pending", {26'd0, bus.pending}, 32'd0);
    chk("t5_rst_fall",    {26'd0, bus.fall},    32'd0);
    step(10);
    chk("t5_quiet_stable", {26'd0, bus.stable}, 32'd0);

    // 6: all bits together, up then down
    bus.raw = 6'h3F; expect_ev(cyc + 6, 6'h3F, 6'h00);
    step(8);
    chk("t6_stable_up",  {26'd0, bus.stable},  32'h3F);
    chk("t6_pending_up", {26'd0, bus.pending}, 32'h3F);
    bus.raw = 6'h00; expect_ev(cyc + 6, 6'h00, 6'h3F);
    step(8);
    chk("t6_stable_dn",  {26'd0, bus.stable},  32'h00);
    chk("t6_pending_dn", {26'd0, bus.pending}, 32'h3F);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

`default_nettype wire
